// File: rtl/aia_gateway.sv
// aia_gateway: one interrupt source gateway (sync, rectify, edge/level pending).
// Ports: clk_i, rst_ni, irq_src_i, mode_i, setip/clrip/claim_i -> ip_o, rect_o, edge_o.
module aia_gateway #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       irq_src_i,
  input  logic [2:0] mode_i,
  input  logic       setip_i,
  input  logic       clrip_i,
  input  logic       claim_i,
  output logic       ip_o,
  output logic       rect_o,
  output logic       edge_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [2:0] mode_q;
  logic sync_out;
  logic rect_d;
  logic rect_q;
  logic prev_d;
  logic prev_q;
  logic ip_d;
  logic ip_q;
  logic mode_chg;
  logic is_edge;
  logic is_det;
  logic is_lvl;
  logic clr_any;

  assign sync_out = sync_q[SYNC_STAGES-1];

  assign is_edge = (mode_i[2:1] == 2'b10);
  assign is_lvl  = (mode_i[2:1] == 2'b11);
  assign is_det  = (mode_i == 3'd1);

  // Odd active modes (5, 7) are active-low sources.
  assign rect_d = mode_i[2] & (sync_out ^ mode_i[0]);

  assign mode_chg = (mode_i != mode_q);

  // On reconfiguration prev tracks the new rectified value,
  // so the next cycle cannot see a false 0->1.
  assign prev_d = mode_chg ? rect_d : rect_q;

  assign edge_o = is_edge & ~mode_chg & rect_q & ~prev_q;

  assign clr_any = clrip_i | claim_i;

  always_comb begin
    ip_d = 1'b0;
    unique case (1'b1)
      is_edge: ip_d = edge_o | setip_i | (ip_q & ~clr_any);
      is_det:  ip_d = setip_i | (ip_q & ~clr_any);
      is_lvl:  ip_d = rect_q & ~claim_i;
      default: ip_d = 1'b0;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= '0;
      mode_q <= 3'd0;
      rect_q <= 1'b0;
      prev_q <= 1'b0;
      ip_q   <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], irq_src_i};
      mode_q <= mode_i;
      rect_q <= rect_d;
      prev_q <= prev_d;
      ip_q   <= ip_d;
    end
  end

  assign ip_o   = ip_q;
  assign rect_o = rect_q;

endmodule

// File: tb/tb_aia_gateway.sv
// tb_aia_gateway: vector table, directed corner sequences
// and a random run against a behavioural gateway model.
module tb_aia_gateway;

  localparam int SYNC = 2;

  logic       clk_i = 1'b0;
  logic       rst_ni;
  logic       irq_src_i;
  logic [2:0] mode_i;
  logic       setip_i;
  logic       clrip_i;
  logic       claim_i;
  logic       ip_o;
  logic       rect_o;
  logic       edge_o;

  int total = 0;
  int bad = 0;

  aia_gateway #(.SYNC_STAGES(SYNC)) dut (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .irq_src_i (irq_src_i),
    .mode_i    (mode_i),
    .setip_i   (setip_i),
    .clrip_i   (clrip_i),
    .claim_i   (claim_i),
    .ip_o      (ip_o),
    .rect_o    (rect_o),
    .edge_o    (edge_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [2:0] m;
    logic irq, s, c, cl;
    logic ip, rect, edg;
  } vec_t;

  vec_t tq[$];

  // behavioural model state
  bit   mq[$];
  bit   m_rect, m_prev, m_ip;
  logic [2:0] m_last;

  function automatic bit rectify(input logic [2:0] m, input bit v);
    if (m inside {3'd4, 3'd6}) return v;
    if (m inside {3'd5, 3'd7}) return !v;
    return 1'b0;
  endfunction

  function automatic bit m_edge(input logic [2:0] m);
    return (m inside {3'd4, 3'd5}) && (m == m_last) && m_rect && !m_prev;
  endfunction

  task automatic model_reset();
    mq.delete();
    repeat (SYNC) mq.push_back(1'b0);
    m_rect = 0;
    m_prev = 0;
    m_ip = 0;
    m_last = 3'd0;
  endtask

  task automatic model_step();
    bit sv, nr, e;
    sv = mq[SYNC-1];
    nr = rectify(mode_i, sv);
    e = m_edge(mode_i);
    if (mode_i inside {3'd4, 3'd5}) begin
      if (e || setip_i) m_ip = 1;
      else if (clrip_i || claim_i) m_ip = 0;
    end else if (mode_i == 3'd1) begin
      if (setip_i) m_ip = 1;
      else if (clrip_i || claim_i) m_ip = 0;
    end else if (mode_i inside {3'd6, 3'd7}) begin
      m_ip = claim_i ? 1'b0 : m_rect;
    end else begin
      m_ip = 0;
    end
    m_prev = (mode_i != m_last) ? nr : m_rect;
    m_rect = nr;
    m_last = mode_i;
    mq.push_front(irq_src_i);
    void'(mq.pop_back());
  endtask

  task automatic chk(input string nm, input logic a, input logic e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s got=%b want=%b", nm, a, e);
    end
  endtask

  task automatic drive(input logic [2:0] m, input logic irq,
                       input logic s, input logic c, input logic cl);
    mode_i = m;
    irq_src_i = irq;
    setip_i = s;
    clrip_i = c;
    claim_i = cl;
  endtask

  task automatic adv();
    @(posedge clk_i);
    model_step();
    @(negedge clk_i);
  endtask

  task automatic do_reset();
    rst_ni = 1'b0;
    drive(3'd0, 0, 0, 0, 0);
    model_reset();
    repeat (2) @(negedge clk_i);
    rst_ni = 1'b1;
  endtask

  task automatic add(input logic [2:0] m, input logic irq, input logic s,
                     input logic c, input logic cl, input logic ip,
                     input logic rect, input logic edg);
    vec_t v;
    v.m = m; v.irq = irq; v.s = s; v.c = c; v.cl = cl;
    v.ip = ip; v.rect = rect; v.edg = edg;
    tq.push_back(v);
  endtask

  initial begin
    #2000000;
    $display("FAIL timeout total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    int cnt;
    logic [2:0] rm;
    rst_ni = 1'b0;
    drive(3'd4, 1, 0, 0, 0);
    #3;
    chk("rst_ip", ip_o, 1'b0);
    chk("rst_rect", rect_o, 1'b0);
    chk("rst_edge", edge_o, 1'b0);
    @(negedge clk_i);

    // m irq s c cl | ip rect edge
    add(4,0,0,0,0, 0,0,0); add(4,1,0,0,0, 0,0,0);
    add(4,1,0,0,0, 0,0,0); add(4,1,0,0,0, 0,0,0);
    add(4,1,0,0,0, 0,1,1); add(4,1,0,0,0, 1,1,0);
    add(4,1,0,0,1, 1,1,0); add(4,1,0,0,0, 0,1,0);
    add(4,1,0,0,0, 0,1,0); add(5,1,0,0,0, 0,1,0);
    add(5,0,0,0,0, 0,0,0); add(5,0,0,0,0, 0,0,0);
    add(5,0,0,0,0, 0,0,0); add(5,0,0,0,0, 0,1,1);
    add(5,0,0,0,0, 1,1,0); add(5,1,0,0,0, 1,1,0);
    add(5,1,0,0,0, 1,1,0); add(5,1,0,0,0, 1,1,0);
    add(5,1,0,0,0, 1,0,0); add(5,1,0,0,0, 1,0,0);
    add(5,1,0,0,0, 1,0,0); add(1,1,0,1,0, 1,0,0);
    add(1,0,0,0,0, 0,0,0); add(1,1,0,0,0, 0,0,0);
    add(1,0,0,0,0, 0,0,0); add(1,1,1,0,0, 0,0,0);
    add(1,0,0,0,0, 1,0,0); add(1,1,0,1,0, 1,0,0);
    add(1,0,1,1,0, 0,0,0); add(1,0,0,0,0, 1,0,0);
    add(0,0,0,0,0, 1,0,0); add(0,0,1,0,0, 0,0,0);
    add(0,0,0,1,1, 0,0,0);

    do_reset();
    foreach (tq[i]) begin
      drive(tq[i].m, tq[i].irq, tq[i].s, tq[i].c, tq[i].cl);
      #1;
      chk($sformatf("vec%0d_ip", i), ip_o, tq[i].ip);
      chk($sformatf("vec%0d_rect", i), rect_o, tq[i].rect);
      chk($sformatf("vec%0d_edge", i), edge_o, tq[i].edg);
      adv();
    end

    // level-high: claim gives 1,0,1; setip ignored on falling source
    do_reset();
    repeat (5) begin drive(6, 1, 0, 0, 0); adv(); end
    drive(6, 1, 0, 0, 1); #1;
    chk("lvl_claim_c0", ip_o, 1'b1);
    adv();
    drive(6, 1, 0, 0, 0); #1;
    chk("lvl_claim_c1", ip_o, 1'b0);
    adv();
    drive(6, 1, 0, 0, 0); #1;
    chk("lvl_claim_c2", ip_o, 1'b1);
    chk("lvl_no_edge", edge_o, 1'b0);
    adv();
    for (int i = 0; i < 6; i++) begin
      drive(6, 0, 1, 0, 0); #1;
      chk($sformatf("lvl_fall%0d", i), ip_o, (i >= 4) ? 1'b0 : 1'b1);
      adv();
    end

    // level -> edge switch with source high, then edge -> inactive
    do_reset();
    repeat (6) begin drive(6, 1, 0, 0, 0); adv(); end
    drive(4, 1, 0, 0, 0); #1;
    chk("sw_edge", edge_o, 1'b0);
    chk("sw_ip", ip_o, 1'b1);
    adv();
    for (int i = 0; i < 3; i++) begin
      drive(4, 1, 0, 0, 0); #1;
      chk($sformatf("sw_after_edge%0d", i), edge_o, 1'b0);
      chk($sformatf("sw_after_ip%0d", i), ip_o, 1'b1);
      adv();
    end
    drive(0, 1, 0, 0, 0); #1;
    chk("off_ip_c0", ip_o, 1'b1);
    adv();
    drive(0, 1, 0, 0, 0); #1;
    chk("off_ip_c1", ip_o, 1'b0);

    // async reset mid-cycle, then one edge after release
    do_reset();
    repeat (6) begin drive(4, 1, 0, 0, 0); adv(); end
    #1;
    chk("ar_ip_before", ip_o, 1'b1);
    #1;
    rst_ni = 1'b0;
    #1;
    chk("ar_ip_async", ip_o, 1'b0);
    chk("ar_rect_async", rect_o, 1'b0);
    model_reset();
    repeat (2) @(negedge clk_i);
    rst_ni = 1'b1;
    cnt = 0;
    for (int i = 0; i < 8; i++) begin
      drive(4, 1, 0, 0, 0); #1;
      if (edge_o) cnt++;
      adv();
    end
    chk("ar_one_edge", (cnt == 1), 1'b1);
    chk("ar_ip_end", ip_o, 1'b1);

    // random run against the model
    do_reset();
    rm = 3'd4;
    irq_src_i = 1'b0;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 11) == 0) rm = 3'($urandom_range(0, 7));
      drive(rm,
            ($urandom_range(0, 3) == 0) ? ~irq_src_i : irq_src_i,
            ($urandom_range(0, 7) == 0),
            ($urandom_range(0, 7) == 0),
            ($urandom_range(0, 7) == 0));
      #1;
      chk($sformatf("rnd%0d_edge", i), edge_o, m_edge(mode_i));
      chk($sformatf("rnd%0d_rect", i), rect_o, m_rect);
      chk($sformatf("rnd%0d_ip", i), ip_o, m_ip);
      adv();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
